// File: rtl/slave_fifo_tx_arbiter.sv
// Round-robin arbiter sharing the FX2 slave-FIFO write engine among N_CH message channels.
// Grant visible one cycle after a request is sampled; engine RD_REQ is steered only to the granted channel.
module slave_fifo_tx_arbiter #(
  parameter int N_CH        = 4,
  parameter int ID_W        = 2,
  parameter int WDOG_CYCLES = 4096,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_CH-1:0]    CH_ENABLE,
  input  logic [N_CH-1:0]    CH_READY,
  input  logic [N_CH*8-1:0]  CH_LEN,
  input  logic [N_CH*16-1:0] CH_Q,
  output logic [N_CH-1:0]    CH_RD_REQ,
  output logic [N_CH-1:0]    CH_DONE,
  output logic               GOT_FULL_MSG,
  output logic [7:0]         MSG_LEN,
  output logic [15:0]        FIFO_Q,
  input  logic               RD_REQ,
  input  logic               MSG_SENT,
  output logic [ID_W-1:0]    GRANT_ID,
  output logic               BUSY,
  output logic               ERR_TIMEOUT,
  output logic               ERR_OVERRUN
);
  localparam int WD_W  = $clog2(WDOG_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_DONE, S_ABORT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [7:0]       msg_len_q, msg_len_d;
  logic             got_full_q, got_full_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  ch_rd_req;
  logic [N_CH-1:0]  ch_done;
  logic [7:0]       ch_len_a [N_CH];
  logic [15:0]      ch_q_a   [N_CH];
  logic             rr_found;
  logic [ID_W-1:0]  rr_idx;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_len_a[k] = CH_LEN[8*k +: 8];
      ch_q_a[k]   = CH_Q[16*k +: 16];
    end
  end

  assign req = CH_READY & CH_ENABLE;

  // Search begins just past the last grant, so an eligible channel waits at most N_CH-1 messages.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = grant_id_q;
    for (int i = 1; i <= N_CH; i++) begin
      if (!rr_found && req[(int'(grant_id_q) + i) % N_CH]) begin
        rr_found = 1'b1;
        rr_idx   = ID_W'((int'(grant_id_q) + i) % N_CH);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    msg_len_d     = msg_len_q;
    word_cnt_d    = word_cnt_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    ch_rd_req     = '0;
    ch_done       = '0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d    = S_SEND;
          grant_id_d = rr_idx;
          msg_len_d  = ch_len_a[rr_idx];
          word_cnt_d = 8'd0;
          wdog_d     = '0;
        end
      end
      S_SEND: begin
        if (RD_REQ) begin
          if (word_cnt_q < msg_len_q) begin
            ch_rd_req[grant_id_q] = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
          if (word_cnt_q != 8'hFF) begin
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
        // A coinciding MSG_SENT wins over watchdog expiry.
        if (MSG_SENT) begin
          state_d = S_DONE;
        end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DONE: begin
        ch_done[grant_id_q] = 1'b1;
        gap_d               = '0;
        state_d             = S_GAP;
      end
      S_ABORT: begin
        err_timeout_d = 1'b1;
        gap_d         = '0;
        state_d       = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    got_full_d = (state_d == S_SEND);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      grant_id_q    <= ID_W'(N_CH - 1);
      msg_len_q     <= 8'd0;
      got_full_q    <= 1'b0;
      word_cnt_q    <= 8'd0;
      wdog_q        <= '0;
      gap_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      msg_len_q     <= msg_len_d;
      got_full_q    <= got_full_d;
      word_cnt_q    <= word_cnt_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign CH_RD_REQ    = ch_rd_req;
  assign CH_DONE      = ch_done;
  assign GOT_FULL_MSG = got_full_q;
  assign MSG_LEN      = msg_len_q;
  assign FIFO_Q       = ch_q_a[grant_id_q];
  assign GRANT_ID     = grant_id_q;
  assign BUSY         = (state_q != S_IDLE);
  assign ERR_TIMEOUT  = err_timeout_q;
  assign ERR_OVERRUN  = err_overrun_q;
endmodule
